// File: rtl/game_update_scheduler.sv
// Per-frame sequencer: derives the frame tick from the game state, then walks the
// update units in order through a start/done handshake, flagging overruns and hung units.
module game_update_scheduler #(
  parameter int N_UNITS   = 4,
  parameter int FRAME_DIV = 833333,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         game_state,
  output logic [N_UNITS-1:0] unit_start,
  input  logic [N_UNITS-1:0] unit_done,
  output logic               unit_clear,
  output logic               frame_tick,
  output logic               busy,
  output logic [15:0]        frame_count,
  output logic               overrun,
  output logic               timeout_err
);
  localparam int DIV_W = $clog2(FRAME_DIV);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  localparam logic [2:0] GS_START   = 3'd0;
  localparam logic [2:0] GS_PLAYING = 3'd1;
  localparam logic [2:0] GS_PAUSE   = 3'd2;
  localparam logic [2:0] GS_RESET   = 3'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div;
  logic [TMO_W-1:0]   wait_cnt;
  logic [TMO_W-1:0]   wait_cnt_inc;
  logic [IDX_W-1:0]   idx;
  logic [2:0]         last_state;
  logic [N_UNITS-1:0] idx_oh;
  logic               playing;
  logic               paused;
  logic               halted;
  logic               done_hit;
  logic               timed_out;
  logic               last_unit;

  assign playing = (game_state == GS_PLAYING);
  assign paused  = (game_state == GS_PAUSE);
  // START, RESET, GAMEOVER and every undefined code all stop the sequencer
  assign halted  = !playing && !paused;

  for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_idx_dec
    assign idx_oh[gi] = (idx == IDX_W'(gi));
  end

  assign done_hit     = |(unit_done & idx_oh);
  assign wait_cnt_inc = wait_cnt + 1'b1;
  assign timed_out    = (wait_cnt_inc == TMO_W'(TIMEOUT));
  assign last_unit    = (idx == IDX_W'(N_UNITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (playing) begin
        if (div == DIV_W'(FRAME_DIV - 1)) begin
          div        <= '0;
          frame_tick <= 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end else if (!paused) begin
        div <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      unit_start  <= '0;
      busy        <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      unit_clear  <= 1'b0;
      last_state  <= GS_START;
    end else begin
      last_state <= game_state;
      unit_clear <= (game_state == GS_RESET) && (last_state != GS_RESET);
      unit_start <= '0;

      if (halted && state != IDLE) begin
        state <= IDLE;
        idx   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_tick && !halted) begin
              state <= ISSUE;
              idx   <= '0;
              busy  <= 1'b1;
              if (playing) unit_start <= N_UNITS'(1);
            end
          end
          // a zero unit_start here means the issue is parked by PAUSE
          ISSUE: begin
            if (unit_start != '0) begin
              state    <= WAIT;
              wait_cnt <= '0;
            end else if (playing) begin
              unit_start <= idx_oh;
            end
          end
          WAIT: begin
            wait_cnt <= wait_cnt_inc;
            if (done_hit || timed_out) begin
              if (!done_hit) timeout_err <= 1'b1;
              if (last_unit) begin
                state       <= DONE;
                busy        <= 1'b0;
                frame_count <= frame_count + 16'd1;
              end else begin
                state <= ISSUE;
                idx   <= idx + 1'b1;
                if (playing) unit_start <= idx_oh << 1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      if (frame_tick && state != IDLE && !halted) overrun <= 1'b1;

      if (game_state == GS_RESET) begin
        frame_count <= '0;
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
    end
  end
endmodule
